// File: rtl/rdc_pkg.sv
// Shared types and constants for the result dump controller.
// Holds the FSM state encoding, the data memory read latency and the default
// result-window geometry shared with the processor top and the testbench.
package rdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Data memory dump port returns read data this many cycles after mem_rd_en.
    localparam int unsigned MEM_RD_LATENCY = 1;

    localparam int unsigned DEFAULT_REG_WIDTH       = 12;
    localparam int unsigned DEFAULT_ADDR_WIDTH      = 12;
    localparam int unsigned DEFAULT_CORE_COUNT      = 2;
    localparam int unsigned DEFAULT_CYCLE_CNT_WIDTH = 16;
    localparam logic [11:0] DEFAULT_DUMP_BASE       = 12'h800;
    localparam int unsigned DEFAULT_DUMP_LENGTH     = 16;

    // Width of a counter able to hold 0..length, never narrower than 1 bit.
    function automatic int unsigned index_width(input int unsigned length);
        return (length == 0) ? 1 : 32'($clog2(length + 1));
    endfunction

endpackage

// File: rtl/result_dump_controller_if.sv
// Bundles the data memory dump read port and the host-side dump stream.
//   master : controller side (drives mem_rd_en/mem_addr and the dump_* payload)
//   slave  : memory + consumer side (drives mem_dataout and dump_ready)
interface result_dump_controller_if
    import rdc_pkg::*;
#(
    parameter int unsigned reg_width  = DEFAULT_REG_WIDTH,
    parameter int unsigned addr_width = DEFAULT_ADDR_WIDTH
);

    logic                  mem_rd_en;
    logic [addr_width-1:0] mem_addr;
    logic [reg_width-1:0]  mem_dataout;

    logic                  dump_valid;
    logic                  dump_ready;
    logic [reg_width-1:0]  dump_data;
    logic [addr_width-1:0] dump_addr;
    logic                  dump_last;

    modport master (
        output mem_rd_en, mem_addr, dump_valid, dump_data, dump_addr, dump_last,
        input  mem_dataout, dump_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, dump_valid, dump_data, dump_addr, dump_last,
        output mem_dataout, dump_ready
    );

endinterface

// File: rtl/endop_tracker.sv
// Per-core sticky end-of-operation tracking.
// Ports: clk, reset (sync, active-high), clear (drop all sticky bits),
//        enable (accumulate endop_signal), endop_signal[core_count],
//        all_cores_done (every core has finished, counting the live endop too).
module endop_tracker
    import rdc_pkg::*;
#(
    parameter int unsigned core_count = DEFAULT_CORE_COUNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [core_count-1:0] endop_signal,
    output logic                  all_cores_done
);

    logic [core_count-1:0] sticky;

    // Capture pulse-style endop so a core finishing early is not forgotten.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sticky <= '0;
        end else if (enable) begin
            sticky <= sticky | endop_signal;
        end
    end

    // Live endop is ORed in so an all-cores-at-once finish exits the same cycle.
    assign all_cores_done = &(sticky | endop_signal);

endmodule

// File: rtl/result_dump_controller.sv
// Waits for every core to finish, counts RUN cycles, then reads a fixed window
// of data memory through the dump port and streams it out over valid/ready.
// Ports: clk, reset (sync, active-high), start, endop_signal[core_count],
//        bus (dump read port + dump stream, master side),
//        busy, all_done, cycle_count[cycle_cnt_width].
module result_dump_controller
    import rdc_pkg::*;
#(
    parameter int unsigned          reg_width       = DEFAULT_REG_WIDTH,
    parameter int unsigned          addr_width      = DEFAULT_ADDR_WIDTH,
    parameter int unsigned          core_count      = DEFAULT_CORE_COUNT,
    parameter logic [addr_width-1:0] dump_base_addr = addr_width'(DEFAULT_DUMP_BASE),
    parameter int unsigned          dump_length     = DEFAULT_DUMP_LENGTH,
    parameter int unsigned          cycle_cnt_width = DEFAULT_CYCLE_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [core_count-1:0]      endop_signal,
    result_dump_controller_if.master   bus,
    output logic                       busy,
    output logic                       all_done,
    output logic [cycle_cnt_width-1:0] cycle_count
);

    localparam int unsigned          IDX_W        = index_width(dump_length);
    localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'((dump_length == 0) ? 0 : dump_length - 1);
    localparam bit                   EMPTY_WINDOW = (dump_length == 0);

    state_t               state;
    logic [IDX_W-1:0]     index;
    logic [reg_width-1:0] rd_word;
    logic                 arm_c;
    logic                 all_cores_done;

    assign rd_word = bus.mem_dataout;

    // A start pulse only counts while the block is parked.
    assign arm_c = start && ((state == ST_IDLE) || (state == ST_DONE));

    endop_tracker #(
        .core_count (core_count)
    ) u_endop_tracker (
        .clk            (clk),
        .reset          (reset),
        .clear          (arm_c),
        .enable         (state == ST_RUN),
        .endop_signal   (endop_signal),
        .all_cores_done (all_cores_done)
    );

    // Control FSM; every output is registered and set on the transition into
    // the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            index          <= '0;
            cycle_count    <= '0;
            busy           <= 1'b0;
            all_done       <= 1'b0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.dump_valid <= 1'b0;
            bus.dump_data  <= '0;
            bus.dump_addr  <= '0;
            bus.dump_last  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm_c) begin
                        state       <= ST_RUN;
                        index       <= '0;
                        cycle_count <= '0;
                        busy        <= 1'b1;
                        all_done    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + cycle_cnt_width'(1);
                    end
                    if (all_cores_done) begin
                        if (EMPTY_WINDOW) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            all_done <= 1'b1;
                        end else begin
                            state         <= ST_ISSUE;
                            index         <= '0;
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= dump_base_addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    bus.mem_rd_en <= 1'b0;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data lands exactly one cycle after the strobe.
                    bus.dump_data  <= rd_word;
                    bus.dump_addr  <= bus.mem_addr;
                    bus.dump_last  <= (index == LAST_IDX);
                    bus.dump_valid <= 1'b1;
                    state          <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.dump_ready) begin
                        bus.dump_valid <= 1'b0;
                        if (bus.dump_last) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            all_done <= 1'b1;
                        end else begin
                            state         <= ST_ISSUE;
                            index         <= index + IDX_W'(1);
                            bus.mem_rd_en <= 1'b1;
                            // Address wraps modulo 2^addr_width.
                            bus.mem_addr  <= dump_base_addr + addr_width'(index + IDX_W'(1));
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_dump_controller.sv
// Directed testbench for result_dump_controller: three instances cover the
// default 16-word window, a window wrapping past the top of memory, and an
// empty window.
module tb_result_dump_controller;
    import rdc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: base 0x800, 16 words.
    logic        m_start, m_busy, m_all_done;
    logic [1:0]  m_endop;
    logic [15:0] m_cycle_count;
    result_dump_controller_if #(.reg_width(12), .addr_width(12)) m_bus ();

    // Wrapping instance: base 0xFFE, 4 words.
    logic        w_start, w_busy, w_all_done;
    logic [1:0]  w_endop;
    logic [15:0] w_cycle_count;
    result_dump_controller_if #(.reg_width(12), .addr_width(12)) w_bus ();

    // Empty-window instance.
    logic        z_start, z_busy, z_all_done;
    logic [1:0]  z_endop;
    logic [15:0] z_cycle_count;
    result_dump_controller_if #(.reg_width(12), .addr_width(12)) z_bus ();

    result_dump_controller #(
        .reg_width(12), .addr_width(12), .core_count(2),
        .dump_base_addr(12'h800), .dump_length(16), .cycle_cnt_width(16)
    ) u_main (
        .clk(clk), .reset(reset), .start(m_start), .endop_signal(m_endop),
        .bus(m_bus), .busy(m_busy), .all_done(m_all_done), .cycle_count(m_cycle_count)
    );

    result_dump_controller #(
        .reg_width(12), .addr_width(12), .core_count(2),
        .dump_base_addr(12'hFFE), .dump_length(4), .cycle_cnt_width(16)
    ) u_wrap (
        .clk(clk), .reset(reset), .start(w_start), .endop_signal(w_endop),
        .bus(w_bus), .busy(w_busy), .all_done(w_all_done), .cycle_count(w_cycle_count)
    );

    result_dump_controller #(
        .reg_width(12), .addr_width(12), .core_count(2),
        .dump_base_addr(12'h800), .dump_length(0), .cycle_cnt_width(16)
    ) u_zero (
        .clk(clk), .reset(reset), .start(z_start), .endop_signal(z_endop),
        .bus(z_bus), .busy(z_busy), .all_done(z_all_done), .cycle_count(z_cycle_count)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [11:0] mem_pattern(input logic [11:0] a);
        return (a * 12'd7) ^ 12'hA5C;
    endfunction

    // Memory models: data appears MEM_RD_LATENCY cycles after the strobe,
    // garbage otherwise so a mistimed capture is visible.
    logic [11:0] m_pipe [MEM_RD_LATENCY];
    logic [11:0] w_pipe [MEM_RD_LATENCY];
    logic [11:0] z_pipe [MEM_RD_LATENCY];
    always @(posedge clk) begin
        m_pipe[0] <= m_bus.mem_rd_en ? mem_pattern(m_bus.mem_addr) : 12'hBAD;
        w_pipe[0] <= w_bus.mem_rd_en ? mem_pattern(w_bus.mem_addr) : 12'hBAD;
        z_pipe[0] <= z_bus.mem_rd_en ? mem_pattern(z_bus.mem_addr) : 12'hBAD;
        for (int i = 1; i < int'(MEM_RD_LATENCY); i++) begin
            m_pipe[i] <= m_pipe[i-1];
            w_pipe[i] <= w_pipe[i-1];
            z_pipe[i] <= z_pipe[i-1];
        end
    end
    assign m_bus.mem_dataout = m_pipe[MEM_RD_LATENCY-1];
    assign w_bus.mem_dataout = w_pipe[MEM_RD_LATENCY-1];
    assign z_bus.mem_dataout = z_pipe[MEM_RD_LATENCY-1];

    // Stream monitors: log read strobes and accepted words.
    int          m_rd_cnt = 0;
    int          w_rd_cnt = 0;
    int          z_rd_cnt = 0;
    int          z_valid_cnt = 0;
    logic [11:0] m_q_addr[$];
    logic [11:0] m_q_data[$];
    logic        m_q_last[$];
    logic [11:0] w_q_addr[$];
    logic [11:0] w_q_data[$];
    logic        w_q_last[$];
    always @(negedge clk) begin
        if (m_bus.mem_rd_en) m_rd_cnt++;
        if (w_bus.mem_rd_en) w_rd_cnt++;
        if (z_bus.mem_rd_en) z_rd_cnt++;
        if (z_bus.dump_valid) z_valid_cnt++;
        if (m_bus.dump_valid && m_bus.dump_ready) begin
            m_q_addr.push_back(m_bus.dump_addr);
            m_q_data.push_back(m_bus.dump_data);
            m_q_last.push_back(m_bus.dump_last);
        end
        if (w_bus.dump_valid && w_bus.dump_ready) begin
            w_q_addr.push_back(w_bus.dump_addr);
            w_q_data.push_back(w_bus.dump_data);
            w_q_last.push_back(w_bus.dump_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
        checks++; if (m_all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done: got %b expected 0", m_all_done); end
        checks++; if (m_cycle_count !== 16'h0) begin errors++; $display("FAIL reset_cycle_count: got %h expected 0000", m_cycle_count); end
        checks++; if (m_bus.dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid: got %b expected 0", m_bus.dump_valid); end
        checks++; if (m_bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en: got %b expected 0", m_bus.mem_rd_en); end
        checks++; if (w_bus.mem_addr !== 12'h0) begin errors++; $display("FAIL reset_wrap_mem_addr: got %h expected 000", w_bus.mem_addr); end
        checks++; if (z_all_done !== 1'b0) begin errors++; $display("FAIL reset_zero_all_done: got %b expected 0", z_all_done); end
        reset = 1'b0;
        tick();
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", m_busy); end
    endtask

    task automatic test_main_dump();
        int base;
        int rd0;
        int n;
        logic [11:0] ea;
        base = m_q_addr.size();
        rd0  = m_rd_cnt;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL main_busy_run: got %b expected 1", m_busy); end
        for (int c = 0; c < 10; c++) begin
            m_endop = (c == 5) ? 2'b01 : ((c == 9) ? 2'b10 : 2'b00);
            if (c == 3) begin
                checks++; if (m_cycle_count !== 16'd3) begin errors++; $display("FAIL main_cycle_mid: got %0d expected 3", m_cycle_count); end
            end
            tick();
        end
        m_endop = 2'b00;
        checks++; if (m_cycle_count !== 16'd10) begin errors++; $display("FAIL main_cycle_count: got %0d expected 10", m_cycle_count); end
        checks++; if (m_bus.mem_rd_en !== 1'b1 || m_bus.mem_addr !== 12'h800) begin errors++; $display("FAIL main_first_issue: got rd=%b addr=%h expected rd=1 addr=800", m_bus.mem_rd_en, m_bus.mem_addr); end
        for (int k = 0; k < 200 && m_all_done !== 1'b1; k++) tick();
        checks++; if (m_all_done !== 1'b1) begin errors++; $display("FAIL main_done_timeout: got all_done=%b expected 1", m_all_done); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL main_busy_done: got %b expected 0", m_busy); end
        checks++; if (m_cycle_count !== 16'd10) begin errors++; $display("FAIL main_cycle_frozen: got %0d expected 10", m_cycle_count); end
        checks++; if (m_rd_cnt - rd0 !== 16) begin errors++; $display("FAIL main_rd_count: got %0d expected 16", m_rd_cnt - rd0); end
        n = m_q_addr.size() - base;
        checks++; if (n !== 16) begin errors++; $display("FAIL main_word_count: got %0d expected 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            ea = 12'h800 + 12'(i);
            checks++; if (m_q_addr[base+i] !== ea) begin errors++; $display("FAIL main_addr[%0d]: got %h expected %h", i, m_q_addr[base+i], ea); end
            checks++; if (m_q_data[base+i] !== mem_pattern(ea)) begin errors++; $display("FAIL main_data[%0d]: got %h expected %h", i, m_q_data[base+i], mem_pattern(ea)); end
            checks++; if (m_q_last[base+i] !== (i == 15)) begin errors++; $display("FAIL main_last[%0d]: got %b expected %b", i, m_q_last[base+i], (i == 15)); end
        end
    endtask

    task automatic test_back_to_back_stall();
        int base;
        int rd0;
        int n;
        bit stalled;
        logic [11:0] ea;
        base = m_q_addr.size();
        rd0  = m_rd_cnt;
        stalled = 1'b0;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        checks++; if (m_all_done !== 1'b0 || m_busy !== 1'b1) begin errors++; $display("FAIL rearm: got busy=%b all_done=%b expected busy=1 all_done=0", m_busy, m_all_done); end
        m_endop = 2'b11;
        tick();
        m_endop = 2'b00;
        checks++; if (m_cycle_count !== 16'd1) begin errors++; $display("FAIL rearm_cycle_count: got %0d expected 1", m_cycle_count); end
        for (int k = 0; k < 300 && m_all_done !== 1'b1; k++) begin
            if (!stalled && m_bus.dump_valid === 1'b1 && (m_q_addr.size() - base) == 3) begin
                m_bus.dump_ready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    tick();
                    checks++; if (m_bus.dump_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", s, m_bus.dump_valid); end
                    checks++; if (m_bus.dump_addr !== 12'h803) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 803", s, m_bus.dump_addr); end
                    checks++; if (m_bus.dump_data !== mem_pattern(12'h803)) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", s, m_bus.dump_data, mem_pattern(12'h803)); end
                    checks++; if (m_bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en[%0d]: got %b expected 0", s, m_bus.mem_rd_en); end
                end
                stalled = 1'b1;
                m_bus.dump_ready = 1'b1;
            end
            tick();
        end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_reached: got %b expected 1", stalled); end
        checks++; if (m_all_done !== 1'b1) begin errors++; $display("FAIL stall_done_timeout: got all_done=%b expected 1", m_all_done); end
        checks++; if (m_rd_cnt - rd0 !== 16) begin errors++; $display("FAIL stall_rd_count: got %0d expected 16", m_rd_cnt - rd0); end
        n = m_q_addr.size() - base;
        checks++; if (n !== 16) begin errors++; $display("FAIL stall_word_count: got %0d expected 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            ea = 12'h800 + 12'(i);
            checks++; if (m_q_addr[base+i] !== ea || m_q_data[base+i] !== mem_pattern(ea)) begin errors++; $display("FAIL stall_word[%0d]: got %h/%h expected %h/%h", i, m_q_addr[base+i], m_q_data[base+i], ea, mem_pattern(ea)); end
        end
    endtask

    task automatic test_wrap();
        int base;
        int rd0;
        int n;
        logic [11:0] exp_addr [4];
        exp_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        base = w_q_addr.size();
        rd0  = w_rd_cnt;
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        w_endop = 2'b11;
        tick();
        w_endop = 2'b00;
        checks++; if (w_bus.mem_rd_en !== 1'b1 || w_bus.mem_addr !== 12'hFFE) begin errors++; $display("FAIL wrap_first_issue: got rd=%b addr=%h expected rd=1 addr=ffe", w_bus.mem_rd_en, w_bus.mem_addr); end
        for (int k = 0; k < 100 && w_all_done !== 1'b1; k++) tick();
        checks++; if (w_all_done !== 1'b1) begin errors++; $display("FAIL wrap_done_timeout: got all_done=%b expected 1", w_all_done); end
        checks++; if (w_rd_cnt - rd0 !== 4) begin errors++; $display("FAIL wrap_rd_count: got %0d expected 4", w_rd_cnt - rd0); end
        n = w_q_addr.size() - base;
        checks++; if (n !== 4) begin errors++; $display("FAIL wrap_word_count: got %0d expected 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            checks++; if (w_q_addr[base+i] !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, w_q_addr[base+i], exp_addr[i]); end
            checks++; if (w_q_data[base+i] !== mem_pattern(exp_addr[i])) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, w_q_data[base+i], mem_pattern(exp_addr[i])); end
            checks++; if (w_q_last[base+i] !== (i == 3)) begin errors++; $display("FAIL wrap_last[%0d]: got %b expected %b", i, w_q_last[base+i], (i == 3)); end
        end
    endtask

    task automatic test_zero_length();
        int rd0;
        int v0;
        rd0 = z_rd_cnt;
        v0  = z_valid_cnt;
        z_start = 1'b1;
        tick();
        z_start = 1'b0;
        z_endop = 2'b11;
        tick();
        z_endop = 2'b00;
        checks++; if (z_all_done !== 1'b1) begin errors++; $display("FAIL zero_all_done: got %b expected 1", z_all_done); end
        checks++; if (z_busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", z_busy); end
        checks++; if (z_cycle_count !== 16'd1) begin errors++; $display("FAIL zero_cycle_count: got %0d expected 1", z_cycle_count); end
        for (int k = 0; k < 5; k++) tick();
        checks++; if (z_rd_cnt - rd0 !== 0) begin errors++; $display("FAIL zero_rd_count: got %0d expected 0", z_rd_cnt - rd0); end
        checks++; if (z_valid_cnt - v0 !== 0) begin errors++; $display("FAIL zero_valid_count: got %0d expected 0", z_valid_cnt - v0); end
        checks++; if (z_all_done !== 1'b1) begin errors++; $display("FAIL zero_done_hold: got %b expected 1", z_all_done); end
    endtask

    task automatic test_reset_in_hold();
        int base;
        int rd0;
        int n;
        bit hit;
        logic [11:0] ea;
        base = m_q_addr.size();
        hit = 1'b0;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        m_endop = 2'b11;
        tick();
        m_endop = 2'b00;
        for (int k = 0; k < 300 && !hit; k++) begin
            if (m_bus.dump_valid === 1'b1 && (m_q_addr.size() - base) == 7) begin
                m_bus.dump_ready = 1'b0;
                reset = 1'b1;
                hit = 1'b1;
            end
            tick();
        end
        reset = 1'b0;
        m_bus.dump_ready = 1'b1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rst_hold_reached: got %b expected 1", hit); end
        checks++; if (m_bus.mem_rd_en !== 1'b0 || m_bus.mem_addr !== 12'h0) begin errors++; $display("FAIL rst_hold_mem: got rd=%b addr=%h expected 0/000", m_bus.mem_rd_en, m_bus.mem_addr); end
        checks++; if (m_bus.dump_valid !== 1'b0 || m_bus.dump_last !== 1'b0) begin errors++; $display("FAIL rst_hold_valid_last: got %b/%b expected 0/0", m_bus.dump_valid, m_bus.dump_last); end
        checks++; if (m_bus.dump_data !== 12'h0 || m_bus.dump_addr !== 12'h0) begin errors++; $display("FAIL rst_hold_payload: got %h/%h expected 000/000", m_bus.dump_data, m_bus.dump_addr); end
        checks++; if (m_busy !== 1'b0 || m_all_done !== 1'b0 || m_cycle_count !== 16'h0) begin errors++; $display("FAIL rst_hold_status: got busy=%b done=%b cnt=%h expected 0/0/0000", m_busy, m_all_done, m_cycle_count); end
        n = m_q_addr.size() - base;
        checks++; if (n !== 7) begin errors++; $display("FAIL rst_hold_words: got %0d expected 7", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (m_q_last[base+i] !== 1'b0) begin errors++; $display("FAIL rst_hold_last[%0d]: got %b expected 0", i, m_q_last[base+i]); end
        end
        tick();
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_hold_idle: got busy=%b expected 0", m_busy); end
        base = m_q_addr.size();
        rd0  = m_rd_cnt;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        m_endop = 2'b11;
        tick();
        m_endop = 2'b00;
        for (int k = 0; k < 200 && m_all_done !== 1'b1; k++) tick();
        checks++; if (m_all_done !== 1'b1) begin errors++; $display("FAIL rst_redump_timeout: got all_done=%b expected 1", m_all_done); end
        checks++; if (m_rd_cnt - rd0 !== 16) begin errors++; $display("FAIL rst_redump_rd_count: got %0d expected 16", m_rd_cnt - rd0); end
        n = m_q_addr.size() - base;
        checks++; if (n !== 16) begin errors++; $display("FAIL rst_redump_words: got %0d expected 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            ea = 12'h800 + 12'(i);
            checks++; if (m_q_addr[base+i] !== ea || m_q_data[base+i] !== mem_pattern(ea) || m_q_last[base+i] !== (i == 15)) begin
                errors++; $display("FAIL rst_redump_word[%0d]: got %h/%h/%b expected %h/%h/%b", i, m_q_addr[base+i], m_q_data[base+i], m_q_last[base+i], ea, mem_pattern(ea), (i == 15));
            end
        end
    endtask

    task automatic test_saturation();
        m_endop = 2'b00;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        checks++; if (m_cycle_count !== 16'd101) begin errors++; $display("FAIL sat_start_ignored: got %0d expected 101", m_cycle_count); end
        for (int k = 0; k < 65433; k++) tick();
        checks++; if (m_cycle_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", m_cycle_count); end
        for (int k = 0; k < 4466; k++) tick();
        checks++; if (m_cycle_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count: got %h expected ffff", m_cycle_count); end
        checks++; if (m_busy !== 1'b1 || m_all_done !== 1'b0) begin errors++; $display("FAIL sat_status: got busy=%b done=%b expected 1/0", m_busy, m_all_done); end
        checks++; if (m_bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL sat_rd_en: got %b expected 0", m_bus.mem_rd_en); end
        m_endop = 2'b11;
        tick();
        m_endop = 2'b00;
        for (int k = 0; k < 200 && m_all_done !== 1'b1; k++) tick();
        checks++; if (m_all_done !== 1'b1 || m_cycle_count !== 16'hFFFF) begin errors++; $display("FAIL sat_finish: got done=%b cnt=%h expected 1/ffff", m_all_done, m_cycle_count); end
    endtask

    initial begin
        m_start = 1'b0; m_endop = 2'b00; m_bus.dump_ready = 1'b1;
        w_start = 1'b0; w_endop = 2'b00; w_bus.dump_ready = 1'b1;
        z_start = 1'b0; z_endop = 2'b00; z_bus.dump_ready = 1'b1;
        #2;
        test_reset();
        test_main_dump();
        test_back_to_back_stall();
        test_wrap();
        test_zero_length();
        test_reset_in_hold();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
